// File: rtl/reg_file_wb_pkg.sv
// Shared constants and types for the writeback register file with RAW scoreboard.
// Holds default data width, register count, index width and pending-counter width.
// No logic; imported by the interface and the top.
package reg_file_wb_pkg;
  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = 5;
  localparam int PEND_W    = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_wb_if.sv
// Bundle of writeback, operand-read and issue/stall signals for reg_file_wb.
// master: pipeline side (drives WB, read indices, issue); slave: register file.
// No storage; every slave output is combinational from the register file state.
interface reg_file_wb_if #(
  parameter int XLEN = reg_file_wb_pkg::XLEN
) ();
  import reg_file_wb_pkg::*;

  // writeback stage
  logic            Write_Enable_WB;
  reg_idx_t        Rd_WB;
  logic [XLEN-1:0] Data_Write_Back;
  // decode-stage operand reads
  reg_idx_t        Rs1_ID;
  reg_idx_t        Rs2_ID;
  logic [XLEN-1:0] Read_Data1_ID;
  logic [XLEN-1:0] Read_Data2_ID;
  // decode-stage issue and hazard reporting
  logic            Issue_Valid_ID;
  logic            Issue_Writes_ID;
  reg_idx_t        Issue_Rd_ID;
  logic            Stall_ID;
  logic            Sb_Error;

  modport master (
    output Write_Enable_WB, Rd_WB, Data_Write_Back,
    output Rs1_ID, Rs2_ID,
    output Issue_Valid_ID, Issue_Writes_ID, Issue_Rd_ID,
    input  Read_Data1_ID, Read_Data2_ID, Stall_ID, Sb_Error
  );

  modport slave (
    input  Write_Enable_WB, Rd_WB, Data_Write_Back,
    input  Rs1_ID, Rs2_ID,
    input  Issue_Valid_ID, Issue_Writes_ID, Issue_Rd_ID,
    output Read_Data1_ID, Read_Data2_ID, Stall_ID, Sb_Error
  );
endinterface

// File: rtl/reg_pend_ctr.sv
// Saturating up/down count of in-flight writes to one architectural register.
// Latency: count updates on the next edge; eff and err are combinational.
// Backpressure: none; overflow/underflow holds the count and raises err for that cycle.
// Ports: clk, rst (async active-high), inc (issue accepted), dec (retire),
//        eff (count as seen by this cycle's hazard check), err (saturation event).
module reg_pend_ctr #(
  parameter int PEND_W = reg_file_wb_pkg::PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] eff,
  output logic              err
);
  logic [PEND_W-1:0] cnt;
  logic [PEND_W-1:0] cnt_nxt;

  // Simultaneous inc and dec cancel out, so neither can saturate.
  always_comb begin
    cnt_nxt = cnt;
    err     = 1'b0;
    if (inc && !dec) begin
      if (cnt == '1) err = 1'b1;
      else           cnt_nxt = cnt + PEND_W'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) err = 1'b1;
      else           cnt_nxt = cnt - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  // A retire in this cycle already resolves one pending write, so readers
  // waiting on it need not stall (its data arrives via the bypass).
  assign eff = (dec && cnt != '0) ? cnt - PEND_W'(1) : cnt;
endmodule

// File: rtl/reg_file_wb.sv
// 32-entry register file with write-through bypass and per-register RAW scoreboard.
// Latency: reads and Stall_ID are combinational; writes and counts update on the edge.
// Backpressure: Stall_ID tells decode to hold; a stalled issue is not counted.
// Ports: clk, rst (async active-high), bus (reg_file_wb_if.slave: WB write,
//        two operand reads, issue valid/writes/rd, Stall_ID, sticky Sb_Error).
module reg_file_wb #(
  parameter int XLEN   = reg_file_wb_pkg::XLEN,
  parameter int PEND_W = reg_file_wb_pkg::PEND_W
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_wb_if.slave bus
);
  import reg_file_wb_pkg::*;

  logic [XLEN-1:0]      regs [REG_COUNT];
  logic [PEND_W-1:0]    eff  [REG_COUNT];
  logic [REG_COUNT-1:0] ctr_err;
  logic                 retire;
  logic                 issue_accept;
  logic                 stall;
  logic                 sb_err;
  logic [XLEN-1:0]      rd1;
  logic [XLEN-1:0]      rd2;

  assign retire = bus.Write_Enable_WB && (bus.Rd_WB != '0);

  // x0 is never written because retire excludes index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (retire) begin
      regs[bus.Rd_WB] <= bus.Data_Write_Back;
    end
  end

  // Reads are forced to 0 during reset so an in-flight WB cannot leak
  // through the bypass.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!rst && bus.Rs1_ID != '0)
      rd1 = (retire && bus.Rd_WB == bus.Rs1_ID) ? bus.Data_Write_Back : regs[bus.Rs1_ID];
    if (!rst && bus.Rs2_ID != '0)
      rd2 = (retire && bus.Rd_WB == bus.Rs2_ID) ? bus.Data_Write_Back : regs[bus.Rs2_ID];
  end

  assign bus.Read_Data1_ID = rd1;
  assign bus.Read_Data2_ID = rd2;

  // Stall depends only on retire, never on issue_accept, so there is no
  // combinational loop through the counters.
  assign stall = bus.Issue_Valid_ID && !rst &&
                 ((bus.Rs1_ID != '0 && eff[bus.Rs1_ID] != '0) ||
                  (bus.Rs2_ID != '0 && eff[bus.Rs2_ID] != '0));

  assign issue_accept = bus.Issue_Valid_ID && !stall &&
                        bus.Issue_Writes_ID && (bus.Issue_Rd_ID != '0);

  assign eff[0]     = '0;
  assign ctr_err[0] = 1'b0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_ctr
    reg_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (issue_accept && bus.Issue_Rd_ID == REG_IDX_W'(r)),
      .dec (retire && bus.Rd_WB == REG_IDX_W'(r)),
      .eff (eff[r]),
      .err (ctr_err[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sb_err <= 1'b0;
    else if (|ctr_err) sb_err <= 1'b1;
  end

  assign bus.Stall_ID = stall;
  assign bus.Sb_Error = sb_err;
endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: expectations are queued as each cycle's
// stimulus is driven and popped/compared against the DUT outputs mid-cycle.
// Covers reset, WB write/read, x0, bypass, RAW stall, same-cycle issue+retire,
// saturation errors, and asynchronous mid-operation reset.
module tb_reg_file_wb;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_wb_if #(.XLEN(XLEN)) bus ();

  reg_file_wb #(.XLEN(XLEN), .PEND_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {O_RD1, O_RD2, O_STALL, O_ERR} obs_e;
  typedef struct {
    string           tag;
    obs_e            sel;
    logic [XLEN-1:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input obs_e sel, input logic [XLEN-1:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t            e;
    logic [XLEN-1:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        O_RD1:   obs = bus.Read_Data1_ID;
        O_RD2:   obs = bus.Read_Data2_ID;
        O_STALL: obs = XLEN'(bus.Stall_ID);
        default: obs = XLEN'(bus.Sb_Error);
      endcase
      check_val(e.tag, obs, e.val);
    end
  endtask

  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd_wb, input logic [XLEN-1:0] d,
                       input logic iv, input logic iw, input logic [4:0] ird,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.Write_Enable_WB = we;
    bus.Rd_WB           = rd_wb;
    bus.Data_Write_Back = d;
    bus.Issue_Valid_ID  = iv;
    bus.Issue_Writes_ID = iw;
    bus.Issue_Rd_ID     = ird;
    bus.Rs1_ID          = rs1;
    bus.Rs2_ID          = rs2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    expect_out("rst_rd1", O_RD1, '0);
    expect_out("rst_rd2", O_RD2, '0);
    expect_out("rst_stall", O_STALL, '0);
    expect_out("rst_err", O_ERR, '0);
    cycle();
    rst = 1'b0;

    // Write x5 (announced by an issue first), read back, x0 stays 0.
    drive(0, 0, '0, 1, 1, 5, 0, 0);
    expect_out("iss5_stall", O_STALL, '0);
    cycle();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    expect_out("wb5_err", O_ERR, '0);
    cycle();
    drive(1, 0, 32'h00001234, 0, 0, 0, 5, 0);
    expect_out("rd_x5", O_RD1, 32'hDEADBEEF);
    expect_out("x0_byp", O_RD2, '0);
    expect_out("x0_wr_err", O_ERR, '0);
    cycle();
    drive(0, 0, '0, 0, 0, 0, 5, 0);
    expect_out("x0_after", O_RD2, '0);
    cycle();

    // Write-through bypass on x7.
    drive(0, 0, '0, 1, 1, 7, 0, 0);
    cycle();
    drive(1, 7, 32'hA5A5A5A5, 0, 0, 0, 7, 0);
    expect_out("byp_x7", O_RD1, 32'hA5A5A5A5);
    cycle();
    drive(0, 0, '0, 0, 0, 0, 7, 5);
    expect_out("st_x7", O_RD1, 32'hA5A5A5A5);
    expect_out("st_x5", O_RD2, 32'hDEADBEEF);
    cycle();

    // RAW on x3: stall while pending, released by same-cycle retire.
    drive(0, 0, '0, 1, 1, 3, 0, 0);
    expect_out("iss3_stall", O_STALL, '0);
    cycle();
    drive(0, 0, '0, 1, 0, 0, 3, 0);
    expect_out("raw3_stall", O_STALL, 1);
    cycle();
    drive(1, 3, 32'h33, 1, 0, 0, 3, 0);
    expect_out("ret3_stall", O_STALL, '0);
    expect_out("ret3_byp", O_RD1, 32'h33);
    cycle();
    drive(0, 0, '0, 1, 0, 0, 0, 3);
    expect_out("cnt3_zero", O_STALL, '0);
    expect_out("x3_rd2", O_RD2, 32'h33);
    expect_out("raw3_err", O_ERR, '0);
    cycle();

    // Issue and retire of x4 in the same cycle leave the count at 1.
    drive(0, 0, '0, 1, 1, 4, 0, 0);
    cycle();
    drive(1, 4, 32'h44, 1, 1, 4, 0, 0);
    expect_out("both4_stall", O_STALL, '0);
    cycle();
    drive(0, 0, '0, 0, 0, 0, 4, 0);
    expect_out("novalid_stall", O_STALL, '0);
    cycle();
    drive(0, 0, '0, 1, 0, 0, 4, 0);
    expect_out("cnt4_one", O_STALL, 1);
    expect_out("both4_err", O_ERR, '0);
    cycle();
    drive(1, 4, 32'h45, 1, 0, 0, 4, 0);
    expect_out("ret4_stall", O_STALL, '0);
    cycle();
    drive(0, 0, '0, 1, 0, 0, 4, 0);
    expect_out("cnt4_zero", O_STALL, '0);
    cycle();

    // Async reset mid-cycle with cnt[3]=2 and x3=0x55.
    drive(0, 0, '0, 1, 1, 3, 0, 0);
    cycle();
    drive(1, 3, 32'h55, 1, 1, 3, 0, 0);
    cycle();
    drive(0, 0, '0, 1, 1, 3, 0, 0);
    cycle();
    drive(0, 0, '0, 1, 0, 0, 3, 3);
    expect_out("pre_rst_stall", O_STALL, 1);
    expect_out("pre_rst_x3", O_RD1, 32'h55);
    #1 drain();
    #1 rst = 1'b1;
    #1;
    expect_out("arst_rd1", O_RD1, '0);
    expect_out("arst_rd2", O_RD2, '0);
    expect_out("arst_stall", O_STALL, '0);
    expect_out("arst_err", O_ERR, '0);
    drain();
    @(posedge clk);
    #1;
    drive(1, 6, 32'h66, 1, 1, 6, 6, 0);
    expect_out("inrst_byp", O_RD1, '0);
    expect_out("inrst_stall", O_STALL, '0);
    cycle();
    rst = 1'b0;
    drive(0, 0, '0, 1, 0, 0, 3, 6);
    expect_out("post_rst_stall", O_STALL, '0);
    expect_out("post_rst_x3", O_RD1, '0);
    expect_out("post_rst_x6", O_RD2, '0);
    cycle();

    // Overflow: four accepted issues to x9 saturate at 3.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, '0, 1, 1, 9, 0, 0);
      expect_out("ovf_err_before", O_ERR, '0);
      cycle();
    end
    drive(0, 0, '0, 1, 0, 0, 9, 0);
    expect_out("ovf_err", O_ERR, 1);
    expect_out("ovf_stall", O_STALL, 1);
    cycle();
    // Three retires drain a count of 3; stall clears on the third.
    for (int i = 0; i < 3; i++) begin
      drive(1, 9, XLEN'(32'h90 + i), 1, 0, 0, 9, 0);
      expect_out("drain9_stall", O_STALL, (i == 2) ? 1'b0 : 1'b1);
      cycle();
    end
    drive(0, 0, '0, 1, 0, 0, 9, 0);
    expect_out("cnt9_zero", O_STALL, '0);
    expect_out("x9_val", O_RD1, 32'h92);
    expect_out("ovf_sticky", O_ERR, 1);
    cycle();

    // Underflow: retire to x10 with no pending write.
    rst = 1'b1;
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    cycle();
    rst = 1'b0;
    drive(1, 10, 32'h1010, 1, 0, 0, 10, 0);
    expect_out("unf_err_before", O_ERR, '0);
    expect_out("unf_stall", O_STALL, '0);
    expect_out("unf_byp", O_RD1, 32'h1010);
    cycle();
    drive(0, 0, '0, 1, 0, 0, 10, 0);
    expect_out("unf_err", O_ERR, 1);
    expect_out("cnt10_zero", O_STALL, '0);
    expect_out("x10_val", O_RD1, 32'h1010);
    cycle();
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    cycle();
    expect_out("unf_sticky", O_ERR, 1);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width.
REQ-002 The block SHALL have parameter PEND_W, default 2, giving the width of each per-register pending-write counter.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port Write_Enable_WB  input  1  writeback strobe from the writeback stage.
REQ-006 Port Rd_WB  input  5  writeback destination register index.
REQ-007 Port Data_Write_Back  input  XLEN  writeback data.
REQ-008 Port Rs1_ID  input  5  and Rs2_ID  input  5: decode-stage source register indices.
REQ-009 Port Read_Data1_ID  output  XLEN  and Read_Data2_ID  output  XLEN: source operand values.
REQ-010 Port Issue_Valid_ID  input  1  decode presents an instruction.
REQ-011 Port Issue_Writes_ID  input  1  the presented instruction writes Issue_Rd_ID.
REQ-012 Port Issue_Rd_ID  input  5  destination register index of the presented instruction.
REQ-013 Port Stall_ID  output  1  RAW hazard; decode SHALL hold the instruction.
REQ-014 Port Sb_Error  output  1  sticky scoreboard overflow/underflow flag.

Function
REQ-015 Storage SHALL be 32 x XLEN registers; x0 SHALL read as 0, and writes to x0 SHALL be ignored.
REQ-016 On a rising edge with Write_Enable_WB=1 and Rd_WB!=0, regs[Rd_WB] SHALL take Data_Write_Back.
REQ-017 Reads SHALL be combinational; if Write_Enable_WB=1, Rd_WB!=0 and Rd_WB==Rs*, Read_Data* SHALL return Data_Write_Back in the same cycle (write-through bypass).
REQ-018 Each register r=1..31 SHALL have a pending counter cnt[r] (PEND_W bits); cnt[0] SHALL be constant 0.
REQ-019 Issue_Accept SHALL be Issue_Valid_ID & ~Stall_ID & Issue_Writes_ID & (Issue_Rd_ID!=0).
REQ-020 Retire SHALL be Write_Enable_WB & (Rd_WB!=0).
REQ-021 Counter update: Issue_Accept only -> cnt+1; Retire only -> cnt-1; both to the same register -> unchanged; both to different registers -> each updated independently.
REQ-022 An increment at cnt = 2^PEND_W-1 SHALL hold the count and set Sb_Error; a decrement at cnt=0 SHALL hold 0 and set Sb_Error.
REQ-023 The effective pending count eff[r] SHALL be cnt[r] minus 1 when Retire targets r this cycle, else cnt[r].
REQ-024 Stall_ID SHALL be Issue_Valid_ID & ((Rs1_ID!=0 & eff[Rs1_ID]>0) | (Rs2_ID!=0 & eff[Rs2_ID]>0)); it is combinational, with zero-cycle latency.
REQ-025 Stall_ID SHALL be 0 whenever Issue_Valid_ID=0.
REQ-026 Sb_Error SHALL remain 1 once set, until reset.

Reset
REQ-027 Asserting rst SHALL immediately clear all 32 registers, all counters and Sb_Error to 0, independent of clk.
REQ-028 While rst=1, writes and issues SHALL be ignored, Read_Data* SHALL read 0, and Stall_ID SHALL be 0.
REQ-029 A reset asserted mid-operation SHALL discard all pending counts, with no residual stall after release.

Structure
REQ-030 A shared package SHALL hold XLEN, REG_COUNT=32, REG_IDX_W=5 and PEND_W.
REQ-031 One sub-module, reg_pend_ctr (a single saturating up/down counter with error output), SHALL be instantiated for r=1..31.

Verification
REQ-032 Write x5=0xDEADBEEF, then read Rs1=5 on the next cycle -> Read_Data1_ID=0xDEADBEEF; write x0=0x1234 -> reading Rs2=0 returns 0.
REQ-033 Same cycle: WE=1, Rd_WB=7, data 0xA5A5A5A5, Rs1_ID=7 -> Read_Data1_ID=0xA5A5A5A5 in that cycle; the stored value is visible afterwards.
REQ-034 Issue a write to x3 (accepted); next cycle Issue_Valid with Rs1=3 -> Stall_ID=1; with WB Rd=3 in that cycle -> Stall_ID=0 and cnt[3]=0.
REQ-035 Issue a write to x4 while WB retires x4 in the same cycle, with cnt[4]=1 -> cnt[4] stays 1 and Sb_Error=0.
REQ-036 Four accepted issues to x9 without retire -> cnt[9]=3 and Sb_Error=1; a retire to x10 with cnt[10]=0 -> Sb_Error=1 and cnt[10]=0.
REQ-037 Assert rst asynchronously with cnt[3]=2 and x3=0x55 -> all outputs 0 before the next edge; after release, reading x3 gives Stall_ID=0 and data 0.
